// File: rtl/byteswap_pkg.sv
// Shared types and helpers for the byte-swapper framer slice.
// Defaults correspond to a 512-bit stream; the top derives its own widths from its parameters.
package byteswap_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int LP_BYTES      = 64;
    localparam int LP_BYTES_LOG2 = 6;
    localparam int LP_KEEP_MAX   = 128;
    localparam int LP_LEN_MAX    = 64;

    // Byte enables of the last beat: all ones for a full beat, else the low rem bytes.
    function automatic logic [LP_KEEP_MAX-1:0] keep_mask(input logic [31:0] rem);
        logic [LP_KEEP_MAX-1:0] mask;
        for (int i = 0; i < LP_KEEP_MAX; i++) begin
            mask[i] = (rem == 32'd0) || ($unsigned(i) < rem);
        end
        return mask;
    endfunction

    // ceil(len / 2**bytes_log2), done as shift plus carry so the maximum length cannot overflow.
    function automatic logic [LP_LEN_MAX-1:0] beat_count(input logic [LP_LEN_MAX-1:0] len,
                                                         input int unsigned bytes_log2);
        logic [LP_LEN_MAX-1:0] rem_mask;
        rem_mask = (64'd1 << bytes_log2) - 64'd1;
        return (len >> bytes_log2) + {63'd0, |(len & rem_mask)};
    endfunction

endpackage

// File: rtl/byteswap_axis_skid.sv
// Generic 2-entry register slice (main + skid) with a registered upstream ready.
// up_en gates acceptance for the coming cycle; downstream ready never reaches s_ready combinationally.
module byteswap_axis_skid #(
    parameter int C_WIDTH = 8
) (
    input  logic               aclk,
    input  logic               areset,
    input  logic               up_en,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [C_WIDTH-1:0] s_data,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [C_WIDTH-1:0] m_data
);

    logic               main_valid_r, skid_valid_r, ready_r;
    logic [C_WIDTH-1:0] main_r, skid_r;
    logic               main_valid_s, skid_valid_s, ready_s;
    logic [C_WIDTH-1:0] main_s, skid_s;
    logic               s_fire_s, m_fire_s;

    // Next contents of both entries; the skid only fills while main is stalled.
    always_comb begin
        s_fire_s     = s_valid & ready_r;
        m_fire_s     = main_valid_r & m_ready;
        main_valid_s = main_valid_r;
        main_s       = main_r;
        skid_valid_s = skid_valid_r;
        skid_s       = skid_r;
        if (!main_valid_r || m_fire_s) begin
            if (skid_valid_r) begin
                main_valid_s = 1'b1;
                main_s       = skid_r;
                skid_valid_s = s_fire_s;
                skid_s       = s_fire_s ? s_data : {C_WIDTH{1'b0}};
            end else if (s_fire_s) begin
                main_valid_s = 1'b1;
                main_s       = s_data;
            end else begin
                main_valid_s = 1'b0;
                main_s       = {C_WIDTH{1'b0}};
            end
        end else if (s_fire_s) begin
            skid_valid_s = 1'b1;
            skid_s       = s_data;
        end else begin
            skid_valid_s = skid_valid_r;
            skid_s       = skid_r;
        end
        ready_s = up_en & ~skid_valid_s;
    end

    // Entry and ready registers; reset empties both entries.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            main_valid_r <= 1'b0;
            skid_valid_r <= 1'b0;
            ready_r      <= 1'b0;
            main_r       <= {C_WIDTH{1'b0}};
            skid_r       <= {C_WIDTH{1'b0}};
        end else begin
            main_valid_r <= main_valid_s;
            skid_valid_r <= skid_valid_s;
            ready_r      <= ready_s;
            main_r       <= main_s;
            skid_r       <= skid_s;
        end
    end

    assign s_ready = ready_r;
    assign m_valid = main_valid_r;
    assign m_data  = main_r;

endmodule

// File: rtl/byteswap_axis_framer.sv
// Frames a raw beat stream into AXI4-Stream with tkeep/tlast from a byte-length command.
// Optional stall counter port enabled by defining BYTESWAP_FRAMER_STALL_CNT_EN.
module byteswap_axis_framer
    import byteswap_pkg::*;
#(
    parameter int C_AXIS_TDATA_WIDTH = 512,
    parameter int C_LENGTH_WIDTH     = 32
) (
    input  logic                            aclk,
    input  logic                            areset,
    input  logic                            ctrl_start,
    input  logic [C_LENGTH_WIDTH-1:0]       ctrl_length,
    output logic                            ctrl_busy,
    output logic                            ctrl_done,
    input  logic                            s_axis_tvalid,
    output logic                            s_axis_tready,
    input  logic [C_AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic [C_AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
    output logic [C_AXIS_TDATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                            m_axis_tlast
`ifdef BYTESWAP_FRAMER_STALL_CNT_EN
    ,
    output logic [31:0]                     stat_stall_cycles
`endif
);

    localparam int LP_NBYTES = C_AXIS_TDATA_WIDTH / 8;
    localparam int LP_LOG2   = $clog2(LP_NBYTES);
    localparam int LP_PW     = C_AXIS_TDATA_WIDTH + LP_NBYTES + 1;

    state_t                    state_r, state_next_s;
    logic [C_LENGTH_WIDTH-1:0] beat_cnt_r, beats_s;
    logic [LP_NBYTES-1:0]      last_keep_r, last_keep_s;
    logic                      busy_r, done_r, busy_next_s, done_next_s, skid_en_s;
    logic                      s_fire_s, m_fire_s, is_last_s, start_acc_s;
    logic [LP_PW-1:0]          in_payload_s, out_payload_s;

    assign beats_s      = C_LENGTH_WIDTH'(beat_count(LP_LEN_MAX'(ctrl_length), LP_LOG2));
    assign last_keep_s  = LP_NBYTES'(keep_mask(32'(ctrl_length[LP_LOG2-1:0])));
    assign s_fire_s     = s_axis_tvalid & s_axis_tready;
    assign m_fire_s     = m_axis_tvalid & m_axis_tready;
    assign is_last_s    = (beat_cnt_r == C_LENGTH_WIDTH'(1));
    assign start_acc_s  = (state_r == ST_IDLE) & ctrl_start;
    assign in_payload_s = {s_axis_tdata, (is_last_s ? last_keep_r : {LP_NBYTES{1'b1}}), is_last_s};

    // State register.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; the tlast beat leaving main is what ends DRAIN.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (ctrl_start) begin
                    state_next_s = (ctrl_length == C_LENGTH_WIDTH'(0)) ? ST_DONE : ST_RUN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (s_fire_s && is_last_s) begin
                    state_next_s = ST_DRAIN;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (m_fire_s && m_axis_tlast) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_DRAIN;
                end
            end
            ST_DONE: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Output decode from the next state so the registered outputs line up with the state.
    always_comb begin
        busy_next_s = (state_next_s == ST_RUN) || (state_next_s == ST_DRAIN);
        done_next_s = (state_next_s == ST_DONE);
        skid_en_s   = (state_next_s == ST_RUN);
    end

    // Registered control outputs.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= busy_next_s;
            done_r <= done_next_s;
        end
    end

    // Beat counter and last-beat keep, latched only by an accepted start.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            beat_cnt_r  <= C_LENGTH_WIDTH'(0);
            last_keep_r <= {LP_NBYTES{1'b0}};
        end else if (start_acc_s) begin
            beat_cnt_r  <= beats_s;
            last_keep_r <= last_keep_s;
        end else if (s_fire_s) begin
            beat_cnt_r  <= beat_cnt_r - C_LENGTH_WIDTH'(1);
        end
    end

    byteswap_axis_skid #(
        .C_WIDTH(LP_PW)
    ) u_skid (
        .aclk    (aclk),
        .areset  (areset),
        .up_en   (skid_en_s),
        .s_valid (s_axis_tvalid),
        .s_ready (s_axis_tready),
        .s_data  (in_payload_s),
        .m_valid (m_axis_tvalid),
        .m_ready (m_axis_tready),
        .m_data  (out_payload_s)
    );

    assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast} = out_payload_s;
    assign ctrl_busy = busy_r;
    assign ctrl_done = done_r;

`ifdef BYTESWAP_FRAMER_STALL_CNT_EN
    logic [31:0] stall_cnt_r;

    // Saturating count of cycles where a framed beat waits on downstream.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            stall_cnt_r <= 32'd0;
        end else if (start_acc_s) begin
            stall_cnt_r <= 32'd0;
        end else if (((state_r == ST_RUN) || (state_r == ST_DRAIN)) && m_axis_tvalid &&
                     !m_axis_tready && (stall_cnt_r != 32'hFFFF_FFFF)) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
        end
    end

    assign stat_stall_cycles = stall_cnt_r;
`endif

endmodule

// File: tb/tb_byteswap_axis_framer.sv
// Scoreboard bench for byteswap_axis_framer: randomized raw beats, expected framed beats queued
// at input handshake and checked by an output monitor.
module tb_byteswap_axis_framer;
    import byteswap_pkg::*;

    logic         aclk = 1'b0;
    logic         areset;
    logic         ctrl_start;
    logic [31:0]  ctrl_length;
    logic         ctrl_busy, ctrl_done;
    logic         s_axis_tvalid, s_axis_tready;
    logic [511:0] s_axis_tdata;
    logic         m_axis_tvalid, m_axis_tready;
    logic [511:0] m_axis_tdata;
    logic [63:0]  m_axis_tkeep;
    logic         m_axis_tlast;
`ifdef BYTESWAP_FRAMER_STALL_CNT_EN
    logic [31:0]  stat_stall_cycles;
`endif

    byteswap_axis_framer dut (
        .aclk          (aclk),
        .areset        (areset),
        .ctrl_start    (ctrl_start),
        .ctrl_length   (ctrl_length),
        .ctrl_busy     (ctrl_busy),
        .ctrl_done     (ctrl_done),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast)
`ifdef BYTESWAP_FRAMER_STALL_CNT_EN
        ,
        .stat_stall_cycles (stat_stall_cycles)
`endif
    );

    typedef struct {
        logic [511:0] data;
        logic [63:0]  keep;
        logic         last;
    } beat_t;

    beat_t       exp_q[$];
    int          checks = 0, errors = 0;
    int          cyc = 0;
    int          s_pct = 0, m_pct = 100, m_stall_left = 0;
    logic        s_hs_r = 1'b0;
    int unsigned cur_len = 0;
    int          cur_beats = 0, beat_idx = 0, beats_out = 0;
    int          done_cnt = 0, done_cycle = -1, last_cycle = -100, max_buf = 0;
    logic [63:0] last_keep_seen = 64'd0;

    initial forever #5 aclk = ~aclk;

    always @(posedge aclk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference keep for beat idx of a len-byte transfer of nb beats.
    function automatic logic [63:0] model_keep(input int unsigned len, input int idx, input int nb);
        logic [63:0] k;
        int unsigned tail;
        if (idx + 1 < nb) return {64{1'b1}};
        tail = len - 64 * (nb - 1);
        for (int b = 0; b < 64; b++) k[b] = (b < tail);
        return k;
    endfunction

    // Raw beat source (AXI-compliant hold) and downstream ready generator.
    initial forever begin
        @(posedge aclk);
        #1;
        if (!s_axis_tvalid || s_hs_r) begin
            s_axis_tvalid = ($urandom_range(0, 99) < s_pct);
            for (int w = 0; w < 16; w++) s_axis_tdata[w*32 +: 32] = $urandom();
        end
        if (m_stall_left > 0) begin
            m_axis_tready = 1'b0;
            m_stall_left--;
        end else begin
            m_axis_tready = ($urandom_range(0, 99) < m_pct);
        end
    end

    // Monitor: pops and checks delivered beats, pushes expectations for accepted beats.
    initial forever begin
        beat_t e;
        logic  s_hs;
        @(negedge aclk);
        if (areset) begin
            s_hs_r = 1'b0;
        end else begin
            s_hs = s_axis_tvalid && s_axis_tready;
            if (m_axis_tvalid && m_axis_tready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat actual tlast=%0b expected no beat", m_axis_tlast);
                end else begin
                    e = exp_q.pop_front();
                    if (m_axis_tdata !== e.data || m_axis_tkeep !== e.keep || m_axis_tlast !== e.last) begin
                        errors++;
                        $display("FAIL beat%0d actual data=%h keep=%h last=%0b expected data=%h keep=%h last=%0b",
                                 beats_out, m_axis_tdata, m_axis_tkeep, m_axis_tlast, e.data, e.keep, e.last);
                    end
                    if (m_axis_tlast) begin
                        last_cycle     = cyc;
                        last_keep_seen = m_axis_tkeep;
                    end
                    beats_out++;
                end
            end
            if (s_hs) begin
                if (beat_idx >= cur_beats) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_accept actual beat %0d expected at most %0d", beat_idx + 1, cur_beats);
                end else begin
                    e.data = s_axis_tdata;
                    e.keep = model_keep(cur_len, beat_idx, cur_beats);
                    e.last = (beat_idx == cur_beats - 1);
                    exp_q.push_back(e);
                end
                beat_idx++;
            end
            if (exp_q.size() > max_buf) max_buf = exp_q.size();
            if (s_axis_tready && !ctrl_busy) begin
                checks++;
                errors++;
                $display("FAIL ready_when_idle actual tready=1 expected 0");
            end
            if (ctrl_done) begin
                done_cnt++;
                done_cycle = cyc;
                chk("busy_low_with_done", {63'd0, ctrl_busy}, 64'd0);
            end
            s_hs_r = s_hs;
        end
    end

    task automatic run_xfer(input int unsigned len, input int sp, input int mp,
                            input int spur, input int stall_after, input int stall_len);
        int d0, start_c;
        logic got, stalled;
        s_pct = sp; m_pct = mp;
        cur_len = len; cur_beats = (len + 63) / 64;
        beat_idx = 0; beats_out = 0; last_cycle = -100; max_buf = 0;
        d0 = done_cnt; got = 1'b0; stalled = 1'b0;
        @(posedge aclk);
        #1;
        ctrl_start = 1'b1; ctrl_length = len; start_c = cyc;
        @(posedge aclk);
        #1;
        ctrl_start = 1'b0; ctrl_length = $urandom();
        if (len > 0) chk("busy_after_start", {63'd0, ctrl_busy}, 64'd1);
        for (int i = 0; i < 4000 && !got; i++) begin
            @(negedge aclk);
            if (i == spur) begin
                ctrl_start = 1'b1; ctrl_length = 32'd64;
            end else if (i == spur + 1) begin
                ctrl_start = 1'b0;
            end
            if (stall_len > 0 && !stalled && beats_out >= stall_after && m_axis_tvalid) begin
                m_stall_left = stall_len; stalled = 1'b1;
            end
            if (ctrl_done) got = 1'b1;
        end
        ctrl_start = 1'b0;
        #1;
        chk("done_seen", {63'd0, got}, 64'd1);
        chk("beats_delivered", 64'(beats_out), 64'(cur_beats));
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        chk("done_timing", 64'(done_cycle), (len == 0) ? 64'(start_c + 1) : 64'(last_cycle + 1));
        chk("max_buffered_le2", {63'd0, (max_buf <= 2)}, 64'd1);
        @(negedge aclk);
        chk("done_one_cycle", {63'd0, ctrl_done}, 64'd0);
        chk("done_count", 64'(done_cnt - d0), 64'd1);
    endtask

    initial begin
        int d0;
        areset = 1'b1; ctrl_start = 1'b0; ctrl_length = 32'd0;
        s_axis_tvalid = 1'b0; s_axis_tdata = 512'd0; m_axis_tready = 1'b0;
        repeat (3) @(negedge aclk);
        chk("rst_busy",   {63'd0, ctrl_busy},     64'd0);
        chk("rst_done",   {63'd0, ctrl_done},     64'd0);
        chk("rst_sready", {63'd0, s_axis_tready}, 64'd0);
        chk("rst_mvalid", {63'd0, m_axis_tvalid}, 64'd0);
        chk("rst_mlast",  {63'd0, m_axis_tlast},  64'd0);
        chk("rst_mkeep",  m_axis_tkeep,           64'd0);
        chk("beats_at_max_len", beat_count(64'h0000_0000_FFFF_FFFF, 6), 64'd67108864);
        @(posedge aclk);
        #1;
        areset = 1'b0;

        run_xfer(256, 100, 100, -1, 0, 0);
        chk("len256_last_keep", last_keep_seen, {64{1'b1}});
        run_xfer(100, 100, 100, -1, 0, 0);
        chk("len100_last_keep", last_keep_seen, 64'h0000_000F_FFFF_FFFF);
        run_xfer(0, 100, 100, -1, 0, 0);
        run_xfer(640, 100, 100, -1, 3, 12);

        // Abort mid-transfer, then a fresh single-beat transfer.
        s_pct = 100; m_pct = 100;
        cur_len = 256; cur_beats = 4; beat_idx = 0; beats_out = 0;
        @(posedge aclk);
        #1;
        ctrl_start = 1'b1; ctrl_length = 32'd256;
        @(posedge aclk);
        #1;
        ctrl_start = 1'b0;
        for (int i = 0; i < 200 && beat_idx < 2; i++) @(negedge aclk);
        chk("abort_two_accepted", {63'd0, (beat_idx >= 2)}, 64'd1);
        #2;
        areset = 1'b1;
        #1;
        chk("abort_mvalid", {63'd0, m_axis_tvalid}, 64'd0);
        chk("abort_busy",   {63'd0, ctrl_busy},     64'd0);
        chk("abort_sready", {63'd0, s_axis_tready}, 64'd0);
        exp_q.delete();
        d0 = done_cnt;
        @(posedge aclk);
        #1;
        areset = 1'b0;
        repeat (5) @(negedge aclk);
        chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
        run_xfer(64, 100, 100, -1, 0, 0);
        chk("len64_last_keep", last_keep_seen, {64{1'b1}});

        run_xfer(256, 100, 100, 3, 0, 5);
`ifdef BYTESWAP_FRAMER_STALL_CNT_EN
        chk("stall_cycles", {32'd0, stat_stall_cycles}, 64'd5);
`endif

        run_xfer(1, 70, 80, -1, 0, 0);
        run_xfer(63, 60, 60, -1, 0, 0);
        run_xfer(65, 90, 50, -1, 0, 0);
        for (int t = 0; t < 8; t++) begin
            run_xfer($urandom_range(1, 800), $urandom_range(30, 100), $urandom_range(30, 100),
                     -1, $urandom_range(0, 4), $urandom_range(0, 6));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/byteswap_axis_framer.md
Name: byteswap_axis_framer

Overview:
Upstream neighbour of the byte-swapper stage. Takes the raw, unframed beat stream from the kernel read master and a byte-length command, and emits a framed AXI4-Stream with correct tkeep and tlast for the swapper's slave port. The last beat carries a partial tkeep and tlast. Issues a done pulse to the kernel control logic once the final beat has left the block.

Parameters:
C_AXIS_TDATA_WIDTH, 512, data width of both streams in bits (multiple of 8, power of two).
C_LENGTH_WIDTH, 32, width of the byte-length command.

Ports:
aclk  in  1  sole clock.
areset  in  1  asynchronous, active-high reset.
ctrl_start  in  1  one-cycle start pulse, sampled only in IDLE.
ctrl_length  in  C_LENGTH_WIDTH  transfer length in bytes, latched with ctrl_start.
ctrl_busy  out  1  high in RUN and DRAIN.
ctrl_done  out  1  one-cycle pulse when the transfer completes.
s_axis_tvalid  in  1  raw beat valid from the read master.
s_axis_tready  out  1  registered ready.
s_axis_tdata  in  C_AXIS_TDATA_WIDTH  raw beat data.
m_axis_tvalid  out  1  framed beat valid.
m_axis_tready  in  1  downstream ready.
m_axis_tdata  out  C_AXIS_TDATA_WIDTH  beat data, passed unchanged.
m_axis_tkeep  out  C_AXIS_TDATA_WIDTH/8  byte enables.
m_axis_tlast  out  1  final beat of the transfer.

Behaviour:
- Reset (asynchronous, active-high): state IDLE; skid buffer emptied.
  - All outputs 0: ctrl_busy, ctrl_done, s_axis_tready, m_axis_tvalid, m_axis_tlast.
  - m_axis_tkeep = 0; m_axis_tdata is don't-care.
- Derived constants:
  - LP_BYTES = C_AXIS_TDATA_WIDTH/8.
  - beats = ceil(len/LP_BYTES).
  - rem = len mod LP_BYTES.
  - Last-beat tkeep = all ones if rem==0, else the low rem bits set.
  - All other beats: tkeep all ones.
- States: IDLE, RUN, DRAIN, DONE.
  - IDLE: on ctrl_start, latch len, beat counter = beats, last keep = mask. If len==0 go to DONE, otherwise go to RUN.
  - RUN: accept input beats while counter>0. Counter decrements on each s_axis handshake. The beat accepted at counter==1 is tagged tlast with the last keep mask. That handshake moves the state to DRAIN.
  - DRAIN: s_axis_tready=0. Leave when the tlast beat completes its m_axis handshake, then go to DONE.
  - DONE: ctrl_done=1 for exactly one cycle, then IDLE.
- ctrl_start outside IDLE is ignored; length is not re-latched.
- Output path: 2-entry skid buffer (main register plus skid register).
  - s_axis_tready is a register: 1 in RUN when the skid register is empty and counter>1, or when counter==1 and both entries are free enough to take the final beat. No combinational path from m_axis_tready to s_axis_tready.
  - Latency: a beat accepted in cycle N is visible on m_axis in cycle N+1 if the main register was empty.
  - Sustained throughput: 1 beat/cycle when m_axis_tready=1.
  - m_axis_tvalid, once high, holds with stable tdata/tkeep/tlast until its handshake.
- Input beats presented in IDLE, DRAIN or DONE are not accepted (tready=0). They stay pending at the read master.
- Counter width is C_LENGTH_WIDTH. beats is computed without overflow at len = 2^C_LENGTH_WIDTH-1.
- areset mid-transfer discards buffered beats immediately; no tlast or done is issued for the aborted transfer.

Optional Feature:
Macro BYTESWAP_FRAMER_STALL_CNT_EN.
- Defined: adds output port stat_stall_cycles (32 bits).
  - Clears on an accepted ctrl_start.
  - Increments each cycle in RUN or DRAIN with m_axis_tvalid=1 and m_axis_tready=0.
  - Saturates at all ones; reset value 0.
- Undefined: port and counter are absent; behaviour otherwise identical.

Decomposition:
- Package byteswap_pkg holds:
  - state encoding (IDLE/RUN/DRAIN/DONE);
  - LP_BYTES and the log2 of LP_BYTES;
  - the keep-mask function (rem -> tkeep);
  - the beat-count function (len -> beats).
- One sub-module: byteswap_axis_skid. It is a generic 2-entry register slice carrying {tdata, tkeep, tlast} with a registered upstream ready. The framer FSM and counter stay in the top module.

Test Plan:
1. W=512, len=256, m_tready=1 -> 4 beats, tkeep=all ones, tlast only on beat 4, ctrl_done 1 cycle after beat 4 handshake, ctrl_busy low with done.
2. len=100 -> 2 beats; beat 2 tkeep=64'h0000_000F_FFFF_FFFF (36 bytes), tlast=1; data bit-identical to input.
3. len=0 -> ctrl_done asserted in the cycle after start, no m_axis_tvalid, s_axis_tready stays 0.
4. len=640 (10 beats), m_tready held 0 for 12 cycles mid-stream -> at most 2 beats buffered, s_axis_tready falls within 1 cycle of skid full, all 10 beats delivered in order with no loss or duplication.
5. len=256, areset pulsed after 2 beats accepted -> m_axis_tvalid and ctrl_busy 0 immediately, no done; new start with len=64 -> single beat, tkeep all ones, tlast=1, done.
6. ctrl_start pulsed with len=64 while busy on len=256 -> ignored; exactly 4 beats and one done; with BYTESWAP_FRAMER_STALL_CNT_EN, 5 forced stall cycles -> stat_stall_cycles=5.
